tc_prog_delay_line: RTL and testbench

Runtime-programmable delay line with a parameterized maximum depth. Delays a `size`-bit input by a run-time selected number of enabled clock edges. Placed directly downstream of a fixed two-stage delay line in generated netlists, wherever the required delay is set by a register rather than fixed at elaboration. Implemented as a zero-initialised ring buffer with a registered output and a fill-tracking `valid` flag.

---
 rtl/tc_delay_pkg.sv | 46 ++++
 rtl/tc_mod_counter.sv | 25 ++
 rtl/tc_prog_delay_line.sv | 70 +++++++
 tb/tb_tc_prog_delay_line.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tc_delay_pkg.sv
// Shared helpers for ring-buffer based delay components: width math,
// run-time depth clamping and modulo pointer subtraction.
package tc_delay_pkg;

  // Library-wide default depth for programmable delay lines.
  localparam int default_max_depth = 16;

  // Ceiling log2, evaluated at elaboration time; returns at least 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Width of a port that must encode every value 0..max_depth inclusive.
  function automatic int depth_width(input int max_depth);
    return clog2(max_depth + 1);
  endfunction

  // A requested delay of 0 means one register stage; oversize requests
  // saturate at the physical buffer length.
  function automatic int clamp_depth(input int depth, input int max_depth);
    if (depth == 0) begin
      return 1;
    end
    if (depth > max_depth) begin
      return max_depth;
    end
    return depth;
  endfunction

  // (a - b) mod modulus for a, b in 0..modulus-1; works for any modulus,
  // not only powers of two.
  function automatic int wrap_sub(input int a, input int b, input int modulus);
    int r;
    r = a - b;
    if (r < 0) begin
      r = r + modulus;
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_mod_counter.sv
// Enable-gated modulo counter, 0..modulus-1, used as a ring-buffer pointer.
module tc_mod_counter #(
  parameter int modulus = 16,
  parameter int width   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [width-1:0] count
);

  // Advance on enabled edges with an explicit wrap back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      if (count == width'(modulus - 1)) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc_prog_delay_line.sv
// Run-time programmable delay line: a zero-initialised ring buffer with a
// registered output and a flag telling whether the output holds real data.
module tc_prog_delay_line
  import tc_delay_pkg::*;
#(
  parameter int size      = 1,
  parameter int max_depth = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [depth_width(max_depth)-1:0] depth,
  input  logic [size-1:0]                   in,
  output logic [size-1:0]                   out,
  output logic                              valid
);

  localparam int dw    = depth_width(max_depth);
  localparam int ptr_w = clog2(max_depth);

  logic [size-1:0]  mem [max_depth];
  logic [ptr_w-1:0] wptr;
  logic [ptr_w-1:0] rd_idx;
  logic [dw-1:0]    fill;
  logic [dw-1:0]    fill_next;
  int               de;

  tc_mod_counter #(
    .modulus(max_depth),
    .width  (ptr_w)
  ) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .count(wptr)
  );

  // Effective delay, read slot for the sample De-1 writes back, and the
  // saturated fill level this edge will produce.
  always_comb begin
    de        = clamp_depth(int'(depth), max_depth);
    rd_idx    = ptr_w'(wrap_sub(int'(wptr), de - 1, max_depth));
    fill_next = (fill == dw'(max_depth)) ? fill : fill + 1'b1;
  end

  // Sample storage; cleared on reset so pre-fill reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < max_depth; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[wptr] <= in;
    end
  end

  // Fill tracking plus registered output and validity, all frozen when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill  <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      fill  <= fill_next;
      out   <= (de == 1) ? in : mem[rd_idx];
      valid <= (int'(fill_next) >= de);
    end
  end

endmodule

// File: tb/tb_tc_prog_delay_line.sv
// Scoreboard bench for tc_prog_delay_line: directed vectors push expected
// outputs, a monitor pops and compares one entry per clock edge.
module tb_tc_prog_delay_line;

  typedef struct {
    logic [7:0] out;
    logic       valid;
    int         wptr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en16, en5;
  logic [4:0] depth16;
  logic [2:0] depth5;
  logic [7:0] in16, in5;
  logic [7:0] out16, out5;
  logic       valid16, valid5;

  exp_t q16[$];
  exp_t q5[$];
  int   checks;
  int   errors;

  tc_prog_delay_line #(.size(8), .max_depth(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en16),
    .depth(depth16),
    .in   (in16),
    .out  (out16),
    .valid(valid16)
  );

  tc_prog_delay_line #(.size(8), .max_depth(5)) dut5 (
    .clk  (clk),
    .rst  (rst),
    .en   (en5),
    .depth(depth5),
    .in   (in5),
    .out  (out5),
    .valid(valid5)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] act_out, input logic act_valid,
                             input logic [7:0] exp_out, input logic exp_valid,
                             input int act_wptr, input int exp_wptr);
    checks++;
    if (act_out !== exp_out) begin
      errors++;
      $display("[TB] FAIL %s out: got %0d expected %0d at %0t", name, act_out, exp_out, $time);
    end
    checks++;
    if (act_valid !== exp_valid) begin
      errors++;
      $display("[TB] FAIL %s valid: got %0b expected %0b at %0t", name, act_valid, exp_valid, $time);
    end
    if (exp_wptr >= 0) begin
      checks++;
      if (act_wptr != exp_wptr) begin
        errors++;
        $display("[TB] FAIL %s wptr: got %0d expected %0d at %0t", name, act_wptr, exp_wptr, $time);
      end
    end
  endtask

  // One vector per clock: drive inputs after the falling edge and record
  // what each output must read just after the following rising edge.
  task automatic applyStimulus(input bit use5, input bit e, input int d, input int din,
                               input int xo, input bit xv, input int xw);
    exp_t x;
    @(negedge clk);
    x.out   = 8'(xo);
    x.valid = xv;
    x.wptr  = xw;
    if (use5) begin
      en16   = 1'b0;
      en5    = e;
      depth5 = 3'(d);
      in5    = 8'(din);
      q5.push_back(x);
    end else begin
      en5     = 1'b0;
      en16    = e;
      depth16 = 5'(d);
      in16    = 8'(din);
      q16.push_back(x);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    en16 = 1'b0;
    en5  = 1'b0;
    rst  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q16.size() > 0) begin
        e = q16.pop_front();
        checkOutput("d16", out16, valid16, e.out, e.valid, int'(dut.wptr), e.wptr);
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        checkOutput("d5", out5, valid5, e.out, e.valid, -1, -1);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    en16    = 1'b0;
    en5     = 1'b0;
    depth16 = '0;
    depth5  = '0;
    in16    = '0;
    in5     = '0;

    doReset();
    #1;
    checkOutput("reset16", out16, valid16, 8'd0, 1'b0, int'(dut.wptr), 0);
    checkOutput("reset5", out5, valid5, 8'd0, 1'b0, -1, -1);

    // Depth 3: out 0,0,1,2,3,4 with valid rising alongside out=1.
    $display("[TB] depth 3 basic stream");
    applyStimulus(0, 1, 3, 1, 0, 0, -1);
    applyStimulus(0, 1, 3, 2, 0, 0, -1);
    applyStimulus(0, 1, 3, 3, 1, 1, -1);
    applyStimulus(0, 1, 3, 4, 2, 1, -1);
    applyStimulus(0, 1, 3, 5, 3, 1, -1);
    applyStimulus(0, 1, 3, 6, 4, 1, 6);

    // Depth 0 acts as a single register stage.
    $display("[TB] depth 0 clamps to 1");
    doReset();
    applyStimulus(0, 1, 0, 10, 10, 1, -1);
    applyStimulus(0, 1, 0, 11, 11, 1, -1);
    applyStimulus(0, 1, 0, 12, 12, 1, -1);

    // Depth 20 clamps to 16: first sample appears after the 16th edge.
    $display("[TB] depth 20 clamps to 16");
    doReset();
    for (int k = 0; k < 18; k++) begin
      applyStimulus(0, 1, 20, k + 1, (k >= 15) ? k - 14 : 0, (k >= 15), -1);
    end

    // Non power-of-two ring: max_depth 5, depth 5, stream 1..12.
    $display("[TB] max_depth 5 wrap-around");
    doReset();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 1, 5, k + 1, (k >= 4) ? k - 3 : 0, (k >= 4), -1);
    end

    // Depth 2 with a three-edge enable gap: everything freezes, then resumes.
    $display("[TB] enable gap");
    doReset();
    applyStimulus(0, 1, 2, 1, 0, 0, 1);
    applyStimulus(0, 1, 2, 2, 1, 1, 2);
    applyStimulus(0, 1, 2, 3, 2, 1, 3);
    applyStimulus(0, 1, 2, 4, 3, 1, 4);
    applyStimulus(0, 0, 2, 99, 3, 1, 4);
    applyStimulus(0, 0, 2, 98, 3, 1, 4);
    applyStimulus(0, 0, 2, 97, 3, 1, 4);
    applyStimulus(0, 1, 2, 5, 4, 1, 5);
    applyStimulus(0, 1, 2, 6, 5, 1, 6);

    // Grow depth 2 -> 6 after four samples: valid drops, then returns.
    $display("[TB] depth growth");
    doReset();
    applyStimulus(0, 1, 2, 1, 0, 0, -1);
    applyStimulus(0, 1, 2, 2, 1, 1, -1);
    applyStimulus(0, 1, 2, 3, 2, 1, -1);
    applyStimulus(0, 1, 2, 4, 3, 1, -1);
    applyStimulus(0, 1, 6, 5, 0, 0, -1);
    applyStimulus(0, 1, 6, 6, 1, 1, -1);
    applyStimulus(0, 1, 6, 7, 2, 1, -1);
    // Shrinking back keeps valid high and jumps to the nearer sample.
    applyStimulus(0, 1, 3, 8, 6, 1, -1);

    // Asynchronous reset between edges, then no stale data afterwards.
    $display("[TB] mid-stream async reset");
    doReset();
    applyStimulus(0, 1, 3, 1, 0, 0, -1);
    applyStimulus(0, 1, 3, 2, 0, 0, -1);
    applyStimulus(0, 1, 3, 3, 1, 1, -1);
    applyStimulus(0, 1, 3, 4, 2, 1, -1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", out16, valid16, 8'd0, 1'b0, int'(dut.wptr), 0);
    en16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 1, 3, 20, 0, 0, -1);
    applyStimulus(0, 1, 3, 21, 0, 0, -1);
    applyStimulus(0, 1, 3, 22, 20, 1, -1);

    @(negedge clk);
    en16 = 1'b0;
    en5  = 1'b0;
    repeat (2) @(negedge clk);

    checks++;
    if ((q16.size() + q5.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", q16.size() + q5.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
